// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin arbiter sharing one 3-to-8 select decoder among 8 requesters.
// Optional build macro GRANT_TIMEOUT_EN adds a grant-length limit of TIMEOUT cycles.  Rev 1.0
`default_nettype none

module decoder_rr_arbiter #(
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [(1<<IDX_W)-1:0]   req,
    output logic                    gnt_valid,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic [(1<<IDX_W)-1:0]   gnt_onehot,
    output logic                    timeout_hit
);

    localparam int N = 1 << IDX_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (IDX_W != 3 || TIMEOUT < 1) begin : g_param_check
        $error("decoder_rr_arbiter: IDX_W must be 3 and TIMEOUT at least 1");
    end

    logic [0:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] next_after;
    logic [IDX_W-1:0] scan_base;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic             force_rel;
    logic             release_evt;
    logic             grant_load;

    assign next_after = gnt_idx + IDX_W'(1);

`ifdef GRANT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt;

    assign force_rel = (state == ST_GRANT) && req[gnt_idx] && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (grant_load) begin
            cnt <= '0;
        end else if (state == ST_GRANT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    assign release_evt = (state == ST_GRANT) && (!req[gnt_idx] || force_rel);

    // On release the scan starts just past the current owner, i.e. at the updated ptr.
    assign scan_base = (state == ST_GRANT) ? next_after : ptr;

    // Scan downwards so the lowest offset from scan_base wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = scan_base + IDX_W'(k);
            if (req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign grant_load = en && win_found && ((state == ST_IDLE) || release_evt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            gnt_valid   <= 1'b0;
            gnt_idx     <= '0;
            gnt_onehot  <= '0;
            timeout_hit <= 1'b0;
        end else begin
            timeout_hit <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_load) begin
                        state      <= ST_GRANT;
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= win_idx;
                        gnt_onehot <= N'(1) << win_idx;
                    end
                end
                ST_GRANT: begin
                    if (!en || release_evt) begin
                        ptr         <= next_after;
                        timeout_hit <= en && force_rel;
                        if (grant_load) begin
                            gnt_idx    <= win_idx;
                            gnt_onehot <= N'(1) << win_idx;
                        end else begin
                            state      <= ST_IDLE;
                            gnt_valid  <= 1'b0;
                            gnt_idx    <= '0;
                            gnt_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    gnt_valid  <= 1'b0;
                    gnt_idx    <= '0;
                    gnt_onehot <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed self-checking bench for decoder_rr_arbiter.  Rev 1.0
`default_nettype none

module tb_decoder_rr_arbiter;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic       timeout_hit;

    int n_cmp = 0;
    int n_err = 0;

    decoder_rr_arbiter #(.IDX_W(3), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .timeout_hit(timeout_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 8'h00;
        en  = 1'b1;
        rst = 1'b1;
        step();
        step();
        if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00 || gnt_idx !== 3'd0 || timeout_hit !== 1'b0) begin
            $display("FAIL reset_state: valid=%b idx=%0d onehot=%h to=%b, required 0/0/00/0",
                     gnt_valid, gnt_idx, gnt_onehot, timeout_hit);
            n_err++;
        end
        n_cmp++;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00) begin
                $display("FAIL idle_no_req cycle %0d: valid=%b onehot=%h, required 0/00", c, gnt_valid, gnt_onehot);
                n_err++;
            end
            n_cmp++;
        end
    endtask

    task automatic test_basic();
        req = 8'h24;
        step();
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2 || gnt_onehot !== 8'h04) begin
            $display("FAIL first_grant: valid=%b idx=%0d onehot=%h, required 1/2/04", gnt_valid, gnt_idx, gnt_onehot);
            n_err++;
        end
        n_cmp++;
        req = 8'h20;
        step();
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5 || gnt_onehot !== 8'h20) begin
            $display("FAIL b2b_grant: valid=%b idx=%0d onehot=%h, required 1/5/20", gnt_valid, gnt_idx, gnt_onehot);
            n_err++;
        end
        n_cmp++;
        req = 8'h00;
        step();
        if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00) begin
            $display("FAIL release_idle: valid=%b onehot=%h, required 0/00", gnt_valid, gnt_onehot);
            n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        logic [7:0] exp_oh;
        reset_pulse();
        req = 8'hFF;
        step();
        for (int g = 0; g < 9; g++) begin
            exp    = 3'(g % 8);
            exp_oh = 8'h01 << exp;
            if (gnt_valid !== 1'b1 || gnt_idx !== exp || gnt_onehot !== exp_oh) begin
                $display("FAIL rr_order grant %0d: valid=%b idx=%0d onehot=%h, required 1/%0d/%h",
                         g, gnt_valid, gnt_idx, gnt_onehot, exp, exp_oh);
                n_err++;
            end
            n_cmp++;
            step();
            step();
            if (gnt_idx !== exp) begin
                $display("FAIL rr_hold grant %0d: idx=%0d, required %0d", g, gnt_idx, exp);
                n_err++;
            end
            n_cmp++;
            req = 8'hFF & ~exp_oh;
            step();
            req = 8'hFF;
        end
        req = 8'h00;
        step();
        step();
    endtask

    task automatic test_async_reset();
        req = 8'h08;
        step();
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd3) begin
            $display("FAIL pre_reset_grant: valid=%b idx=%0d, required 1/3", gnt_valid, gnt_idx);
            n_err++;
        end
        n_cmp++;
        #2 rst = 1'b1;
        #1;
        if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00) begin
            $display("FAIL async_reset_drop: valid=%b onehot=%h, required 0/00", gnt_valid, gnt_onehot);
            n_err++;
        end
        n_cmp++;
        #1 rst = 1'b0;
        req = 8'h82;
        step();
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd1 || gnt_onehot !== 8'h02) begin
            $display("FAIL ptr_after_reset: valid=%b idx=%0d onehot=%h, required 1/1/02", gnt_valid, gnt_idx, gnt_onehot);
            n_err++;
        end
        n_cmp++;
        req = 8'h00;
        step();
    endtask

    task automatic test_enable();
        req = 8'h40;
        step();
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd6) begin
            $display("FAIL grant_six: valid=%b idx=%0d, required 1/6", gnt_valid, gnt_idx);
            n_err++;
        end
        n_cmp++;
        en = 1'b0;
        step();
        if (gnt_valid !== 1'b0 || gnt_onehot !== 8'h00) begin
            $display("FAIL en_drop: valid=%b onehot=%h, required 0/00", gnt_valid, gnt_onehot);
            n_err++;
        end
        n_cmp++;
        req = 8'h41;
        step();
        if (gnt_valid !== 1'b0) begin
            $display("FAIL en_low_idle: valid=%b, required 0", gnt_valid);
            n_err++;
        end
        n_cmp++;
        en = 1'b1;
        step();
        if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0 || gnt_onehot !== 8'h01) begin
            $display("FAIL en_ptr_wrap: valid=%b idx=%0d onehot=%h, required 1/0/01", gnt_valid, gnt_idx, gnt_onehot);
            n_err++;
        end
        n_cmp++;
        req = 8'h00;
        step();
    endtask

    task automatic test_timeout();
        logic [2:0] exp;
        reset_pulse();
        req = 8'h03;
        step();
`ifdef GRANT_TIMEOUT_EN
        for (int r = 0; r < 3; r++) begin
            exp = 3'(r % 2);
            for (int c = 0; c < 16; c++) begin
                if (gnt_valid !== 1'b1 || gnt_idx !== exp || timeout_hit !== (c == 0 && r != 0)) begin
                    $display("FAIL timeout_hold round %0d cycle %0d: valid=%b idx=%0d to=%b, required 1/%0d/%b",
                             r, c, gnt_valid, gnt_idx, timeout_hit, exp, (c == 0 && r != 0));
                    n_err++;
                end
                n_cmp++;
                step();
            end
        end
        if (gnt_idx !== 3'd1 || timeout_hit !== 1'b1) begin
            $display("FAIL timeout_switch: idx=%0d to=%b, required 1/1", gnt_idx, timeout_hit);
            n_err++;
        end
        n_cmp++;
`else
        exp = 3'd0;
        for (int c = 0; c < 40; c++) begin
            if (gnt_valid !== 1'b1 || gnt_idx !== exp || timeout_hit !== 1'b0) begin
                $display("FAIL persistent_hold cycle %0d: valid=%b idx=%0d to=%b, required 1/0/0",
                         c, gnt_valid, gnt_idx, timeout_hit);
                n_err++;
            end
            n_cmp++;
            step();
        end
`endif
        req = 8'h00;
        step();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 8'h00;
        step();
        test_reset();
        test_basic();
        test_back_to_back();
        test_async_reset();
        test_enable();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
